alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multicycle control FSM that drives the ALU's 3-bit operation code and consumes its zero and slt flag outputs.
- Accepts one 8-bit instruction per handshake, then sequences decode, execute, memory and writeback.
- Issues register-file write, memory read/write and PC-update strobes.
- Sits between instruction fetch and the datapath of the 8-bit processor.

Parameters:
- MEM_TIMEOUT, 15, max cycles S_MEM waits for mem_ready before aborting (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word present on instr
- instr  in  8  [7:4] opcode, [3:2] rs, [1:0] rt/imm
- instr_ready  out  1  sequencer can accept an instruction
- alu_ctrl  out  3  ALU operation code
- alu_zero  in  1  ALU zero/branch flag
- alu_slt  in  1  ALU less-than flag
- reg_write  out  1  one-cycle register-file write strobe
- slt_write  out  1  one-cycle slt-register write strobe
- slt_sel  out  1  selects slt0 (0) or slt1 (1); equals latched instr[0]
- mem_read  out  1  load request, held until mem_ready or timeout
- mem_write  out  1  store request, held until mem_ready or timeout
- mem_ready  in  1  memory completion
- pc_inc  out  1  one-cycle PC+1 strobe
- pc_load  out  1  one-cycle branch/jump target load strobe
- mem_err  out  1  sticky: memory timeout occurred
- illegal  out  1  one-cycle pulse: undefined opcode
- retired  out  8  retired-instruction count, wraps 255->0

Behaviour:
- All outputs registered. While rst is high: every output 0, state S_IDLE, counters 0.
- ALU codes:
  - 000 idle
  - 001 add (add, addi)
  - 010 nand
  - 011 compare (slt, blt)
  - 100 shl
  - 101 shr
  - 110 equal (beq)
  - 111 address (lw, sw)
- Opcodes:
  - 0000 nop
  - 0001 add
  - 0010 addi
  - 0011 nand
  - 0100 sll
  - 0101 srl
  - 0110 slt
  - 0111 beq
  - 1000 blt
  - 1001 lw
  - 1010 sw
  - 1011 jump
  - 1100-1111 illegal
- States and transitions:
  - S_IDLE: next cycle -> S_FETCH unconditionally.
  - S_FETCH: instr_ready=1, alu_ctrl=000. On instr_valid: latch instr, instr_ready drops, -> S_DECODE.
  - S_DECODE: alu_ctrl=000, which guarantees the ALU sees a code change on every operation.
    - nop: pc_inc.
    - jump: pc_load.
    - Both then -> S_FETCH.
    - Illegal opcode: illegal pulse plus pc_inc, -> S_FETCH; retired is not incremented.
    - All others -> S_EXEC.
  - S_EXEC: alu_ctrl=code, held through all later states of this instruction. Exactly 1 cycle, then:
    - ALU ops and slt -> S_WB.
    - beq/blt -> S_BR.
    - lw/sw -> S_MEM.
  - S_WB:
    - reg_write=1, except slt which gives slt_write=1 and requires alu_slt=1; slt with alu_slt=0 writes nothing.
    - pc_inc, -> S_FETCH.
  - S_BR: sample alu_zero. 1 -> pc_load, 0 -> pc_inc. -> S_FETCH.
  - S_MEM:
    - mem_read (lw) or mem_write (sw) held high; wait counter counts from 0.
    - On mem_ready: lw -> S_WB (reg_write); sw -> pc_inc, -> S_FETCH.
    - If counter reaches MEM_TIMEOUT without mem_ready: drop request, set mem_err, pc_inc, -> S_FETCH.
    - mem_ready on the same cycle the counter hits the limit counts as success.
- Latency, from the accept cycle:
  - ALU/slt: 4 cycles.
  - Branch: 4 cycles.
  - lw: 5+wait cycles.
  - sw: 4+wait cycles.
  - nop/jump/illegal: 2 cycles.
  - Next instr_ready is 1 cycle after the pc strobe.
- Strobes:
  - Exactly one of pc_inc/pc_load pulses per accepted instruction.
  - reg_write and slt_write are never high together.
  - mem_read and mem_write are never high together.
- retired increments on the pc strobe cycle of every legal instruction, including aborted memory ops.
- mem_err is cleared only by rst.
- instr_valid outside S_FETCH is ignored. The latched instr is stable until the next S_FETCH.
- rst mid-instruction: immediate return to reset values. No strobe completes.

Test Plan:
- Reset release, then instr=0x16 (add) valid -> instr_ready=0 next cycle; alu_ctrl 000 in DECODE, 001 in EXEC/WB; reg_write and pc_inc pulse 4th cycle; retired=1.
- beq (0x7x) with alu_zero=1 -> alu_ctrl=110, pc_load=1, pc_inc=0. Repeat with alu_zero=0 -> pc_inc only.
- lw with mem_ready after 3 wait cycles -> mem_read high 4 cycles, then reg_write, alu_ctrl=111 throughout. sw with mem_ready never asserted -> mem_read/mem_write drop after 15 cycles, mem_err=1 sticky, pc_inc.
- Opcode 0xC0 -> illegal pulse, pc_inc, retired unchanged. Then slt with instr[0]=1, alu_slt=1 -> slt_write=1, slt_sel=1, reg_write=0.
- 256 nops -> retired wraps to 0. rst asserted during S_MEM -> all outputs 0 asynchronously, S_IDLE, then instr_ready=1 two clocks after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multicycle control FSM for the 8-bit processor: sequences decode, execute, memory and
// writeback for one accepted instruction and drives the ALU opcode, write strobes and PC update.
module alu_op_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [2:0] alu_ctrl,
    input  logic       alu_zero,
    input  logic       alu_slt,
    output logic       reg_write,
    output logic       slt_write,
    output logic       slt_sel,
    output logic       mem_read,
    output logic       mem_write,
    input  logic       mem_ready,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mem_err,
    output logic       illegal,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_BR,
        S_MEM
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BLT  = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_JUMP = 4'd11;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    logic [3:0] op_q;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic [7:0] retired_q;
    logic [7:0] retired_d;
    logic       instr_ready_q;
    logic [2:0] alu_ctrl_q;
    logic       reg_write_q;
    logic       slt_write_q;
    logic       slt_sel_q;
    logic       mem_read_q;
    logic       mem_write_q;
    logic       pc_inc_q;
    logic       pc_load_q;
    logic       mem_err_q;
    logic       illegal_q;
    logic       illegal_op;
    logic       unused_instr_bits;

    // Only the opcode and the slt-register select bit steer the sequencer.
    assign unused_instr_bits = ^instr[3:1];

    assign wait_d     = wait_q + 8'd1;
    assign retired_d  = retired_q + 8'd1;
    assign illegal_op = (op_q[3:2] == 2'b11);

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        code = 3'b000;
        case (op)
            4'd1, 4'd2:   code = 3'b001;
            4'd3:         code = 3'b010;
            4'd4:         code = 3'b100;
            4'd5:         code = 3'b101;
            4'd6, 4'd8:   code = 3'b011;
            4'd7:         code = 3'b110;
            4'd9, 4'd10:  code = 3'b111;
            default:      code = 3'b000;
        endcase
        return code;
    endfunction

    // Every instruction ends with exactly one pc strobe; the FETCH cycle that carries it
    // keeps instr_ready low so the next handshake opens one cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= 4'd0;
            wait_q        <= 8'd0;
            retired_q     <= 8'd0;
            instr_ready_q <= 1'b0;
            alu_ctrl_q    <= 3'b000;
            reg_write_q   <= 1'b0;
            slt_write_q   <= 1'b0;
            slt_sel_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            mem_err_q     <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            slt_write_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    alu_ctrl_q <= 3'b000;
                    if (!instr_ready_q) begin
                        instr_ready_q <= 1'b1;
                    end else if (instr_valid) begin
                        op_q          <= instr[7:4];
                        slt_sel_q     <= instr[0];
                        instr_ready_q <= 1'b0;
                        state_q       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (illegal_op) begin
                        illegal_q <= 1'b1;
                        pc_inc_q  <= 1'b1;
                        state_q   <= S_FETCH;
                    end else if (op_q == OP_NOP) begin
                        pc_inc_q  <= 1'b1;
                        retired_q <= retired_d;
                        state_q   <= S_FETCH;
                    end else if (op_q == OP_JUMP) begin
                        pc_load_q <= 1'b1;
                        retired_q <= retired_d;
                        state_q   <= S_FETCH;
                    end else begin
                        alu_ctrl_q <= alu_code(op_q);
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_q <= 8'd0;
                    if (op_q == OP_BEQ || op_q == OP_BLT) begin
                        state_q <= S_BR;
                    end else if (op_q == OP_LW) begin
                        mem_read_q <= 1'b1;
                        state_q    <= S_MEM;
                    end else if (op_q == OP_SW) begin
                        mem_write_q <= 1'b1;
                        state_q     <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (op_q == OP_SLT) begin
                        slt_write_q <= alu_slt;
                    end else begin
                        reg_write_q <= 1'b1;
                    end
                    pc_inc_q   <= 1'b1;
                    retired_q  <= retired_d;
                    alu_ctrl_q <= 3'b000;
                    state_q    <= S_FETCH;
                end
                S_BR: begin
                    pc_load_q  <= alu_zero;
                    pc_inc_q   <= !alu_zero;
                    retired_q  <= retired_d;
                    alu_ctrl_q <= 3'b000;
                    state_q    <= S_FETCH;
                end
                S_MEM: begin
                    // A ready arriving in the last allowed wait cycle still completes the access.
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (op_q == OP_LW) begin
                            state_q <= S_WB;
                        end else begin
                            pc_inc_q   <= 1'b1;
                            retired_q  <= retired_d;
                            alu_ctrl_q <= 3'b000;
                            state_q    <= S_FETCH;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_err_q   <= 1'b1;
                        pc_inc_q    <= 1'b1;
                        retired_q   <= retired_d;
                        alu_ctrl_q  <= 3'b000;
                        state_q     <= S_FETCH;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign reg_write   = reg_write_q;
    assign slt_write   = slt_write_q;
    assign slt_sel     = slt_sel_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign pc_inc      = pc_inc_q;
    assign pc_load     = pc_load_q;
    assign mem_err     = mem_err_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a reference model predicts each instruction's
// strobes, latency and counters; a monitor pops predictions whenever a pc strobe appears.
module tb_alu_op_sequencer;

    localparam int TIMEOUT = 15;

    typedef struct {
        int lat;
        int pcInc;
        int pcLoad;
        int regW;
        int sltW;
        int ill;
        int memErr;
        int ret;
        int code;
        int longOp;
        int rdCyc;
        int wrCyc;
        int sel;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [2:0] alu_ctrl;
    logic       alu_zero;
    logic       alu_slt;
    logic       reg_write;
    logic       slt_write;
    logic       slt_sel;
    logic       mem_read;
    logic       mem_write;
    logic       mem_ready;
    logic       pc_inc;
    logic       pc_load;
    logic       mem_err;
    logic       illegal;
    logic [7:0] retired;
    logic [20:0] outs;

    int   vectors;
    int   miscompares;
    exp_t expQ[$];
    logic [7:0] mRetired;
    logic       mMemErr;

    alu_op_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ready(instr_ready),
        .alu_ctrl(alu_ctrl),
        .alu_zero(alu_zero),
        .alu_slt(alu_slt),
        .reg_write(reg_write),
        .slt_write(slt_write),
        .slt_sel(slt_sel),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_ready(mem_ready),
        .pc_inc(pc_inc),
        .pc_load(pc_load),
        .mem_err(mem_err),
        .illegal(illegal),
        .retired(retired)
    );

    assign outs = {instr_ready, alu_ctrl, reg_write, slt_write, slt_sel, mem_read,
                   mem_write, pc_inc, pc_load, mem_err, illegal, retired};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: outcome of one instruction from the opcode table and timing rules.
    function automatic exp_t model(input logic [7:0] ins, input logic z, input logic s,
                                   input int waitCyc);
        exp_t e;
        int   op;
        bit   memOk;
        e = '{default: 0};
        op = int'(ins[7:4]);
        e.sel = int'(ins[0]);
        memOk = (waitCyc < TIMEOUT);
        case (op)
            0: begin e.lat = 2; e.pcInc = 1; end
            11: begin e.lat = 2; e.pcLoad = 1; end
            1, 2, 3, 4, 5: begin
                e.longOp = 1; e.lat = 4; e.regW = 1; e.pcInc = 1;
                e.code = (op <= 2) ? 1 : (op == 3) ? 2 : (op == 4) ? 4 : 5;
            end
            6: begin e.longOp = 1; e.lat = 4; e.code = 3; e.sltW = int'(s); e.pcInc = 1; end
            7, 8: begin
                e.longOp = 1; e.lat = 4; e.code = (op == 7) ? 6 : 3;
                e.pcLoad = int'(z); e.pcInc = int'(!z);
            end
            9, 10: begin
                e.longOp = 1; e.code = 7; e.pcInc = 1;
                if (memOk) begin
                    e.lat = (op == 9) ? 5 + waitCyc : 4 + waitCyc;
                    e.regW = (op == 9) ? 1 : 0;
                    if (op == 9) e.rdCyc = waitCyc + 1; else e.wrCyc = waitCyc + 1;
                end else begin
                    e.lat = 3 + TIMEOUT;
                    if (op == 9) e.rdCyc = TIMEOUT; else e.wrCyc = TIMEOUT;
                    mMemErr = 1'b1;
                end
            end
            default: begin e.lat = 2; e.pcInc = 1; e.ill = 1; end
        endcase
        if (op < 12) mRetired = mRetired + 8'd1;
        e.ret = int'(mRetired);
        e.memErr = int'(mMemErr);
        return e;
    endfunction

    // Issue one instruction, answer its memory request after waitCyc request cycles
    // (never, if waitCyc >= TIMEOUT), and scribble junk on the instruction bus meanwhile.
    task automatic applyStimulus(input logic [7:0] ins, input logic z, input logic s,
                                 input int waitCyc);
        int k;
        int n;
        bit done;
        n = 0;
        do begin @(negedge clk); n++; end while (!instr_ready && n < 50);
        if (!instr_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        expQ.push_back(model(ins, z, s, waitCyc));
        instr = ins;
        instr_valid = 1'b1;
        alu_zero = z;
        alu_slt = s;
        k = 0;
        done = 0;
        n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            if (pc_inc || pc_load) begin
                done = 1;
                instr_valid = 1'b0;
                mem_ready = 1'b0;
            end else begin
                instr_valid = 1'($urandom);
                instr = 8'($urandom);
                if (mem_read || mem_write) begin
                    mem_ready = (k == waitCyc);
                    k++;
                end else begin
                    mem_ready = 1'($urandom);
                end
                @(negedge clk);
                n++;
            end
        end
        if (!done) begin
            checkOutput("strobe_timeout", 0, 1);
            instr_valid = 1'b0;
            mem_ready = 1'b0;
            expQ.delete();
        end
    endtask

    task automatic releaseCheck();
        @(posedge clk);
        #1 checkOutput("ready_1clk_after_release", int'(instr_ready), 0);
        @(posedge clk);
        #1 checkOutput("ready_2clk_after_release", int'(instr_ready), 1);
    endtask

    task automatic resetDuringMem();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!instr_ready && n < 50);
        instr = 8'h91;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (!mem_read && n < 10) begin @(negedge clk); n++; end
        checkOutput("mem_read_before_reset", int'(mem_read), 1);
        #3 rst = 1'b1;
        #1 checkOutput("async_reset_outputs", int'(outs), 0);
        mRetired = 8'd0;
        mMemErr = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("held_reset_outputs", int'(outs), 0);
        rst = 1'b0;
        releaseCheck();
    endtask

    // Monitor: tracks the accepted instruction and scores it when its pc strobe appears.
    initial begin : monitor
        exp_t e;
        int   off;
        int   rdc;
        int   wrc;
        bit   active;
        bit   postStrobe;
        e = '{default: 0};
        off = 0; rdc = 0; wrc = 0; active = 0; postStrobe = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active = 0;
                postStrobe = 0;
            end else begin
                checkOutput("reg_slt_exclusive", int'(reg_write & slt_write), 0);
                checkOutput("mem_rw_exclusive", int'(mem_read & mem_write), 0);
                if (postStrobe) begin
                    checkOutput("ready_after_strobe", int'(instr_ready), 1);
                    postStrobe = 0;
                end
                if (active) begin
                    off++;
                    if (mem_read) rdc++;
                    if (mem_write) wrc++;
                    if (off == 1) checkOutput("decode_alu_ctrl", int'(alu_ctrl), 0);
                    if (e.longOp != 0 && (off == 2 || off == e.lat - 1))
                        checkOutput("exec_alu_ctrl", int'(alu_ctrl), e.code);
                end
                if (pc_inc || pc_load || reg_write || slt_write || illegal) begin
                    if (!active || expQ.size() == 0) begin
                        checkOutput("unexpected_strobe",
                                    int'({pc_inc, pc_load, reg_write, slt_write, illegal}), 0);
                    end else begin
                        void'(expQ.pop_front());
                        checkOutput("latency", off, e.lat);
                        checkOutput("pc_inc", int'(pc_inc), e.pcInc);
                        checkOutput("pc_load", int'(pc_load), e.pcLoad);
                        checkOutput("reg_write", int'(reg_write), e.regW);
                        checkOutput("slt_write", int'(slt_write), e.sltW);
                        checkOutput("illegal", int'(illegal), e.ill);
                        checkOutput("retired", int'(retired), e.ret);
                        checkOutput("mem_err", int'(mem_err), e.memErr);
                        checkOutput("slt_sel", int'(slt_sel), e.sel);
                        checkOutput("mem_read_cycles", rdc, e.rdCyc);
                        checkOutput("mem_write_cycles", wrc, e.wrCyc);
                        active = 0;
                        postStrobe = 1;
                    end
                end
                if (instr_ready && instr_valid) begin
                    if (expQ.size() > 0) begin
                        e = expQ[0];
                        active = 1;
                        off = 0; rdc = 0; wrc = 0;
                    end else begin
                        active = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        vectors = 0;
        miscompares = 0;
        mRetired = 8'd0;
        mMemErr = 1'b0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 8'h00;
        alu_zero = 1'b0;
        alu_slt = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", int'(outs), 0);
        rst = 1'b0;
        releaseCheck();

        applyStimulus(8'h16, 1'b0, 1'b0, 0);
        applyStimulus(8'h70, 1'b1, 1'b0, 0);
        applyStimulus(8'h70, 1'b0, 1'b0, 0);
        applyStimulus(8'h82, 1'b1, 1'b0, 0);
        applyStimulus(8'h90, 1'b0, 1'b0, 3);
        applyStimulus(8'hA0, 1'b0, 1'b0, 255);
        applyStimulus(8'hC0, 1'b0, 1'b0, 0);
        applyStimulus(8'h61, 1'b0, 1'b1, 0);
        applyStimulus(8'h60, 1'b0, 1'b0, 0);
        applyStimulus(8'h95, 1'b0, 1'b0, TIMEOUT - 1);
        applyStimulus(8'hA3, 1'b0, 1'b0, 0);
        applyStimulus(8'hB0, 1'b0, 1'b0, 0);
        applyStimulus(8'h2F, 1'b0, 1'b0, 0);
        applyStimulus(8'h3F, 1'b0, 1'b0, 0);
        applyStimulus(8'h47, 1'b0, 1'b0, 0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 0);
        applyStimulus(8'hF1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 18));
        end

        for (int i = 0; i < 260; i++) begin
            applyStimulus({4'h0, 4'($urandom)}, 1'b0, 1'b0, 0);
        end

        resetDuringMem();
        applyStimulus(8'h16, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
